// File: rtl/gpi_periph.sv
// ============================================================================
// Module      : gpi_periph
// Description : Memory-mapped general-purpose input port. Synchronises and
//               debounces external pins, latches sticky edge flags and raises
//               a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module gpi_periph #(
  parameter int         WIDTH           = 8,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [9:0] BASE_ADDR       = 10'h3F0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       address,
  input  logic [31:0]      data_in,
  input  logic [3:0]       width,
  input  logic             write,
  output logic [31:0]      data_out,
  input  logic [WIDTH-1:0] pins,
  output logic             irq
);

  localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [1:0] c_REG_STATE  = 2'd0;
  localparam logic [1:0] c_REG_RISE   = 2'd1;
  localparam logic [1:0] c_REG_FALL   = 2'd2;
  localparam logic [1:0] c_REG_IRQ_EN = 2'd3;

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_state;
  logic [WIDTH-1:0]   r_rise;
  logic [WIDTH-1:0]   r_fall;
  logic [WIDTH-1:0]   r_irq_en;
  logic [c_CNT_W-1:0] r_cnt [WIDTH];
  logic [31:0]        r_data_out;

  logic               w_sel;
  logic               w_wr;
  logic [WIDTH-1:0]   w_accept;
  logic [WIDTH-1:0]   w_clr_rise;
  logic [WIDTH-1:0]   w_clr_fall;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  assign w_sel    = (address[9:4] == BASE_ADDR[9:4]);
  assign w_wr     = w_sel && write && width[0];
  assign w_unused = ^{address[1:0], width[3:1], data_in};

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_sync2[i] != r_state[i]) && (r_cnt[i] == c_CNT_MAX);
    end
  end

  assign w_clr_rise = (w_wr && address[3:2] == c_REG_RISE) ? data_in[WIDTH-1:0] : '0;
  assign w_clr_fall = (w_wr && address[3:2] == c_REG_FALL) ? data_in[WIDTH-1:0] : '0;

  always_comb begin
    w_rd_data = '0;
    case (address[3:2])
      c_REG_STATE:  w_rd_data = 32'(r_state);
      c_REG_RISE:   w_rd_data = 32'(r_rise);
      c_REG_FALL:   w_rd_data = 32'(r_fall);
      c_REG_IRQ_EN: w_rd_data = 32'(r_irq_en);
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_state    <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      r_irq_en   <= '0;
      r_data_out <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= pins;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_state[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_state[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
        end
      end
      // A newly accepted edge overrides a same-cycle W1C of that bit.
      r_rise <= (r_rise & ~w_clr_rise) | (w_accept & r_sync2);
      r_fall <= (r_fall & ~w_clr_fall) | (w_accept & ~r_sync2);
      if (w_wr && address[3:2] == c_REG_IRQ_EN) begin
        r_irq_en <= data_in[WIDTH-1:0];
      end
      r_data_out <= w_sel ? w_rd_data : '0;
    end
  end

  assign data_out = r_data_out;
  assign irq      = |((r_rise | r_fall) & r_irq_en);

endmodule

`default_nettype wire

// File: tb/tb_gpi_periph.sv
// ============================================================================
// Module      : tb_gpi_periph
// Description : Directed self-checking bench for gpi_periph.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns / 1ps

module tb_gpi_periph;

  localparam logic [9:0] c_A_STATE = 10'h3F0;
  localparam logic [9:0] c_A_RISE  = 10'h3F4;
  localparam logic [9:0] c_A_FALL  = 10'h3F8;
  localparam logic [9:0] c_A_EN    = 10'h3FC;

  logic        clk;
  logic        rst_n;
  logic [9:0]  address;
  logic [31:0] data_in;
  logic [3:0]  width;
  logic        write;
  logic [31:0] data_out;
  logic [7:0]  pins;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpi_periph #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR      (10'h3F0)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .data_in (data_in),
    .width   (width),
    .write   (write),
    .data_out(data_out),
    .pins    (pins),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [9:0] a);
    address = a;
    write   = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] w);
    address = a;
    data_in = d;
    width   = w;
    write   = 1'b1;
    tick();
    write   = 1'b0;
    width   = 4'b0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    address = c_A_STATE;
    pins    = 8'hFF;
    rst_n   = 1'b0;
    tick(3);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected %b", irq, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state_rd1: got %h expected %h", data_out, 32'h0);
    end
    tick();
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state_rd2: got %h expected %h", data_out, 32'h0);
    end
    pins = 8'h00;
    do_reset();
  endtask

  task automatic test_press();
    address = c_A_STATE;
    pins    = 8'h01;
    tick(6);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL press_state_early: got %h expected %h", data_out, 32'h0);
    end
    tick();
    n_checks++;
    if (data_out !== 32'h1) begin
      n_fail++;
      $display("FAIL press_state_on_time: got %h expected %h", data_out, 32'h1);
    end
    rd(c_A_RISE);
    n_checks++;
    if (data_out !== 32'h1) begin
      n_fail++;
      $display("FAIL press_rise: got %h expected %h", data_out, 32'h1);
    end
    rd(c_A_FALL);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL press_fall: got %h expected %h", data_out, 32'h0);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL press_irq_masked: got %b expected %b", irq, 1'b0);
    end
  endtask

  task automatic test_glitch();
    pins = 8'h09;
    tick(3);
    pins = 8'h01;
    tick(8);
    rd(c_A_STATE);
    n_checks++;
    if (data_out !== 32'h1) begin
      n_fail++;
      $display("FAIL glitch_state: got %h expected %h", data_out, 32'h1);
    end
    rd(c_A_RISE);
    n_checks++;
    if (data_out !== 32'h1) begin
      n_fail++;
      $display("FAIL glitch_rise: got %h expected %h", data_out, 32'h1);
    end
    rd(c_A_FALL);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL glitch_fall: got %h expected %h", data_out, 32'h0);
    end
  endtask

  task automatic test_w1c_mask();
    pins = 8'h05;
    tick(8);
    rd(c_A_RISE);
    n_checks++;
    if (data_out !== 32'h5) begin
      n_fail++;
      $display("FAIL w1c_rise_pre: got %h expected %h", data_out, 32'h5);
    end
    wr(c_A_EN, 32'h04, 4'b0001);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_irq_set: got %b expected %b", irq, 1'b1);
    end
    wr(c_A_RISE, 32'h04, 4'b0001);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq_clear: got %b expected %b", irq, 1'b0);
    end
    rd(c_A_RISE);
    n_checks++;
    if (data_out !== 32'h1) begin
      n_fail++;
      $display("FAIL w1c_rise_post: got %h expected %h", data_out, 32'h1);
    end
    wr(c_A_EN, 32'hFF, 4'b0010);
    rd(c_A_EN);
    n_checks++;
    if (data_out !== 32'h4) begin
      n_fail++;
      $display("FAIL w1c_en_width_ignored: got %h expected %h", data_out, 32'h4);
    end
    wr(c_A_RISE, 32'h01, 4'b0010);
    rd(c_A_RISE);
    n_checks++;
    if (data_out !== 32'h1) begin
      n_fail++;
      $display("FAIL w1c_rise_width_ignored: got %h expected %h", data_out, 32'h1);
    end
    wr(c_A_STATE, 32'h00, 4'b1111);
    rd(c_A_STATE);
    n_checks++;
    if (data_out !== 32'h5) begin
      n_fail++;
      $display("FAIL w1c_state_ro: got %h expected %h", data_out, 32'h5);
    end
    wr(c_A_EN, 32'h06, 4'b0001);
    n_checks++;
    if (data_out !== 32'h4) begin
      n_fail++;
      $display("FAIL w1c_rw_same_cycle: got %h expected %h", data_out, 32'h4);
    end
    rd(c_A_EN);
    n_checks++;
    if (data_out !== 32'h6) begin
      n_fail++;
      $display("FAIL w1c_en_new: got %h expected %h", data_out, 32'h6);
    end
  endtask

  task automatic test_collision();
    pins = 8'h01;
    tick(8);
    rd(c_A_FALL);
    n_checks++;
    if (data_out !== 32'h4) begin
      n_fail++;
      $display("FAIL coll_fall_set: got %h expected %h", data_out, 32'h4);
    end
    wr(c_A_FALL, 32'h04, 4'b0001);
    rd(c_A_FALL);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL coll_fall_cleared: got %h expected %h", data_out, 32'h0);
    end
    pins = 8'h05;
    tick(5);
    wr(c_A_RISE, 32'h04, 4'b0001);
    rd(c_A_RISE);
    n_checks++;
    if (data_out !== 32'h5) begin
      n_fail++;
      $display("FAIL coll_set_wins: got %h expected %h", data_out, 32'h5);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_irq: got %b expected %b", irq, 1'b1);
    end
  endtask

  task automatic test_decode();
    rd(10'h200);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL dec_miss: got %h expected %h", data_out, 32'h0);
    end
    address = c_A_RISE;
    #1;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL dec_latency_hold: got %h expected %h", data_out, 32'h0);
    end
    tick();
    n_checks++;
    if (data_out !== 32'h5) begin
      n_fail++;
      $display("FAIL dec_rise: got %h expected %h", data_out, 32'h5);
    end
    rd(10'h3F5);
    n_checks++;
    if (data_out !== 32'h5) begin
      n_fail++;
      $display("FAIL dec_low_bits: got %h expected %h", data_out, 32'h5);
    end
    wr(10'h20C, 32'hFF, 4'b0001);
    rd(c_A_EN);
    n_checks++;
    if (data_out !== 32'h6) begin
      n_fail++;
      $display("FAIL dec_write_miss: got %h expected %h", data_out, 32'h6);
    end
    pins = 8'h00;
    do_reset();
    pins = 8'h20;
    tick(3);
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    address = c_A_RISE;
    tick(6);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL dec_reset_discard: got %h expected %h", data_out, 32'h0);
    end
    tick();
    n_checks++;
    if (data_out !== 32'h20) begin
      n_fail++;
      $display("FAIL dec_reset_redebounce: got %h expected %h", data_out, 32'h20);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    address = 10'h0;
    data_in = 32'h0;
    width   = 4'b0000;
    write   = 1'b0;
    pins    = 8'hFF;
    test_reset();
    test_press();
    test_glitch();
    test_w1c_mask();
    test_collision();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
